// File: rtl/codificador_4x2_sinc_pkg.sv
// Shared definitions for the synchronous 4-to-2 priority encoder:
// FSM state encoding and the sizing rule for the debounce counter.
package codificador_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  // Counter width needed to hold values up to debounce-1, never below one bit
  function automatic int cnt_width(input int debounce);
    int w;
    w = $clog2(debounce);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/codificador_4x2_sinc_sincronizador_2ff.sv
// Two-flop synchronizer bringing asynchronous board lines into the clk domain.
module sincronizador_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a full cycle to settle
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/codificador_4x2_sinc.sv
// Synchronous 4-to-2 priority encoder with debounce. Raw request lines are
// synchronized, priority-encoded, and a code is accepted only once it has
// been seen unchanged for DEBOUNCE consecutive synchronized samples.
module codificador_4x2_sinc #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic Y3,
  input  logic Y2,
  input  logic Y1,
  input  logic Y0,
  output logic B,
  output logic A,
  output logic V,
  output logic EVT
);

  import codificador_pkg::*;

  localparam int             CW       = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE - 1);

  // Out-of-range debounce lengths are rejected at elaboration
  if (DEBOUNCE < 2 || DEBOUNCE > 255) begin : g_bad_debounce
    $fatal(1, "codificador_4x2_sinc: DEBOUNCE must be in 2..255");
  end

  logic [3:0]    s;
  logic          any;
  logic [1:0]    code;
  state_t        state;
  logic [1:0]    pend;
  logic [CW-1:0] cnt;

  sincronizador_2ff #(
    .WIDTH(4)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  ({Y3, Y2, Y1, Y0}),
    .q  (s)
  );

  // Highest active index wins; priority is re-evaluated every cycle
  always_comb begin
    any  = |s;
    code = 2'd0;
    if (s[3])      code = 2'd3;
    else if (s[2]) code = 2'd2;
    else if (s[1]) code = 2'd1;
  end

  // Debounce FSM: track a pending code, count stable samples, latch on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= 2'd0;
      cnt   <= '0;
      B     <= 1'b0;
      A     <= 1'b0;
      V     <= 1'b0;
      EVT   <= 1'b0;
    end else begin
      EVT <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            pend  <= code;
            cnt   <= CNT_ONE;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (!any) begin
            state <= IDLE;
          end else if (code != pend) begin
            pend <= code;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            B     <= pend[1];
            A     <= pend[0];
            V     <= 1'b1;
            EVT   <= 1'b1;
            state <= LOCK;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        LOCK: begin
          if (!any) begin
            V     <= 1'b0;
            state <= IDLE;
          end else if (code != pend) begin
            V     <= 1'b0;
            pend  <= code;
            cnt   <= CNT_ONE;
            state <= CHECK;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/codificador_4x2_sinc.md
# codificador_4x2_sinc

Synchronous 4-to-2 priority encoder with input synchronization and debounce: the encoding counterpart of the 2x4 decoder. It takes four active-high request/button lines, resolves priority, and accepts a code only after the lines have been stable for DEBOUNCE clocks. It then presents a registered 2-bit code with a valid flag and a one-cycle event pulse. It sits between raw board inputs (buttons, DIP lines) and downstream logic that consumes a clean code, including the 2x4 decoder for loop-back checks.

## Interface
- DEBOUNCE, 4, number of consecutive clocks the synchronized encoded value must stay constant before acceptance; legal range 2..255; values outside this range stop elaboration.
- clk  input  1  clock; all flops update on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Y3  input  1  request line 3; highest priority.
- Y2  input  1  request line 2.
- Y1  input  1  request line 1.
- Y0  input  1  request line 0; lowest priority.
- B  output  1  accepted code MSB.
- A  output  1  accepted code LSB.
- V  output  1  high while the accepted code is held.
- EVT  output  1  one-cycle pulse on each new acceptance.

## Operation
- Input path: Y3..Y0 pass through a 2-flop synchronizer (4 bits wide). The FSM sees only the synchronized value S.
- Priority encode of S gives cand = {any, code}.
  - any = OR of S.
  - code = 3 if S3, else 2 if S2, else 1 if S1, else 0.
  - Multiple active lines resolve to the highest index. Example: S=4'b0110 gives code 2.
- Registers: state, pend (2 b), cnt (ceil(log2(DEBOUNCE)) b, minimum 1), B, A, V, EVT.
- FSM states:
  - IDLE
    - If any=0: stay in IDLE.
    - If any=1: pend=code, cnt=1, go to CHECK.
  - CHECK
    - If any=0: go to IDLE.
    - If code≠pend: pend=code, cnt=1, stay in CHECK.
    - If code=pend and cnt=DEBOUNCE-1: {B,A}=pend, V=1, EVT=1, go to LOCK.
    - Otherwise: cnt=cnt+1.
  - LOCK
    - If any=1 and code=pend: hold outputs.
    - If any=0: V=0, go to IDLE.
    - If code≠pend: V=0, pend=code, cnt=1, go to CHECK.
- B and A keep their last accepted value after V drops. They change only on acceptance.
- EVT is high only on the cycle immediately after the CHECK→LOCK transition. It is never high in two consecutive cycles.
- Re-pressing the same code after release produces a new EVT, because the path goes through IDLE.

## Timing
- Reset (rst=1 at an edge) forces:
  - synchronizer flops to 0;
  - state to IDLE;
  - pend, cnt, B, A, V, EVT to 0.
- rst has priority over every transition, including mid-CHECK and in LOCK. Outputs are 0 the cycle after the reset edge.
- Acceptance latency: if an input is stable from before edge k, V and EVT rise after edge k+DEBOUNCE+1. This is 2 synchronizer cycles plus DEBOUNCE FSM samples.
- Release latency: if the input drops before edge k, V falls after edge k+2.
- Glitch rejection: a change shorter than DEBOUNCE synchronized cycles never produces EVT.
- Simultaneous events:
  - A new code and release of the old code at the same time are treated as a code change.
  - Priority is evaluated fresh on every cycle.
- Counter never wraps. It saturates by construction at DEBOUNCE-1.

## Structure
- Package codificador_pkg holds:
  - the state encoding (IDLE=2'd0, CHECK=2'd1, LOCK=2'd2);
  - the width function for cnt.
- Sub-module sincronizador_2ff:
  - parameter WIDTH, ports clk, rst, d, q;
  - instantiated once with WIDTH=4.
- Priority encode and FSM live in the top module.

## Test plan
All scenarios use DEBOUNCE=4.
- Reset: hold rst for 2 cycles with Y=4'b1111 → B=A=V=EVT=0 during and one cycle after; acceptance occurs 5 cycles after rst release.
- Single line: Y0=1 from before edge 0 → V=1, EVT=1, {B,A}=00 after edge 5; EVT=0 after edge 6; all four lines give codes 00/01/10/11.
- Priority: Y=4'b0111 steady → {B,A}=10, exactly one EVT.
- Glitch: Y1 high for 3 cycles then low → no EVT, V stays 0.
- Change while held:
  - Y1 accepted, then switch to Y3 → V drops 2 cycles after the switch, {B,A} stays 01 until {B,A}=11 with EVT 4 cycles later.
  - Release → V=0 with {B,A}=11 retained.
- Mid-CHECK reset: assert rst when cnt=2 → state IDLE, no EVT; a fresh full debounce is required afterwards.
